// File: rtl/ptp_sync_poller.sv
// ptp_sync_poller
//
// Configures a PTP sync target over an Avalon-MM master port, then polls
// its master/slave travel-time registers and streams every reading out
// through a small first-word-fall-through result FIFO.
//
// Session flow: module reset write -> role write -> sync enable write ->
// { wait POLL_PERIOD cycles -> read master count -> read slave count }*
// -> on stop, sync disable write -> idle.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   start, stop           single-cycle session control pulses
//   role_master           1 = configure target as PTP master (sampled on start)
//   avm_*                 Avalon-MM master (address, read, write, writedata,
//                         readdata, waitrequest)
//   res_valid/res_ready   result stream handshake
//   res_data, res_src     travel-time count and its source (0 master, 1 slave)
//   busy                  session in progress (not IDLE, not ERR)
//   error                 sticky bus-timeout flag, cleared by the next start
//   overflow_cnt          results dropped on a full FIFO, saturating
module ptp_sync_poller #(
    parameter int POLL_PERIOD    = 1000,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        role_master,
    output logic [15:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_src,
    output logic        busy,
    output logic        error,
    output logic [7:0]  overflow_cnt
);

    localparam int PW = $clog2(POLL_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] REG_MASTER = 16'h0000;
    localparam logic [15:0] REG_SYNC   = 16'h0100;
    localparam logic [15:0] REG_RESET  = 16'h0200;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_RST, S_CFG_ROLE, S_CFG_EN, S_WAIT,
        S_RD_M, S_RD_S, S_DIS, S_ERR
    } state_t;

    state_t          state, state_nxt;
    logic            req_q, req_nxt;
    logic            role_q;
    logic            stop_pend;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            error_q;
    logic [7:0]      ovf_q;

    logic            xfer_done, xfer_tmo, stop_any;

    // States that own a bus transfer.
    function automatic logic is_xfer(input state_t s);
        return !(s == S_IDLE || s == S_WAIT || s == S_ERR);
    endfunction

    assign xfer_done = req_q && !avm_waitrequest;
    assign xfer_tmo  = req_q && avm_waitrequest &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    // A stop seen during a transfer is remembered until it completes.
    assign stop_any  = stop || stop_pend;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            req_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= req_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR: if (start) state_nxt = S_CFG_RST;
            S_CFG_RST:     if (xfer_done) state_nxt = stop_any ? S_DIS : S_CFG_ROLE;
            S_CFG_ROLE:    if (xfer_done) state_nxt = stop_any ? S_DIS : S_CFG_EN;
            S_CFG_EN:      if (xfer_done) state_nxt = stop_any ? S_DIS : S_WAIT;
            S_WAIT: begin
                if (stop)                 state_nxt = S_DIS;
                else if (poll_cnt == '0)  state_nxt = S_RD_M;
            end
            S_RD_M:        if (xfer_done) state_nxt = stop_any ? S_DIS : S_RD_S;
            S_RD_S:        if (xfer_done) state_nxt = stop_any ? S_DIS : S_WAIT;
            S_DIS:         if (xfer_done) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
        if (is_xfer(state) && xfer_tmo)
            state_nxt = S_ERR;

        // Moving between two transfer states inserts one request-free cycle;
        // entering a transfer from a non-bus state requests straight away
        // since the bus was already idle.
        if (state_nxt != state)
            req_nxt = is_xfer(state_nxt) && !is_xfer(state);
        else
            req_nxt = is_xfer(state);
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        avm_address   = 16'h0000;
        avm_writedata = 32'h0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        case (state)
            S_CFG_RST: begin
                avm_address   = REG_RESET;
                avm_writedata = 32'h1;
                avm_write     = req_q;
            end
            S_CFG_ROLE: begin
                avm_address   = REG_MASTER;
                avm_writedata = {31'b0, role_q};
                avm_write     = req_q;
            end
            S_CFG_EN: begin
                avm_address   = REG_SYNC;
                avm_writedata = 32'h1;
                avm_write     = req_q;
            end
            S_DIS: begin
                avm_address   = REG_SYNC;
                avm_write     = req_q;
            end
            S_RD_M: begin
                avm_address   = REG_MASTER;
                avm_read      = req_q;
            end
            S_RD_S: begin
                avm_address   = REG_SYNC;
                avm_read      = req_q;
            end
            default: ;
        endcase
        busy = (state != S_IDLE) && (state != S_ERR);
    end

    assign error        = error_q;
    assign overflow_cnt = ovf_q;

    // ------------------------------------------------------------------
    // Session control, poll timer, transfer timeout
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            role_q    <= 1'b0;
            stop_pend <= 1'b0;
            poll_cnt  <= '0;
            wait_cnt  <= '0;
            error_q   <= 1'b0;
        end else begin
            if (start && (state == S_IDLE || state == S_ERR))
                role_q <= role_master;

            if (state_nxt != state)
                stop_pend <= 1'b0;
            else if (stop && is_xfer(state) && state != S_DIS)
                stop_pend <= 1'b1;

            if (state_nxt == S_WAIT && state != S_WAIT)
                poll_cnt <= PW'(POLL_PERIOD - 1);
            else if (state == S_WAIT && poll_cnt != '0)
                poll_cnt <= poll_cnt - PW'(1);

            if (req_q && avm_waitrequest)
                wait_cnt <= wait_cnt + TW'(1);
            else
                wait_cnt <= '0;

            if (xfer_tmo)
                error_q <= 1'b1;
            else if (state == S_ERR && start)
                error_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word fall-through, no empty bypass)
    // ------------------------------------------------------------------
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, full, wr_en, drop;

    assign push  = xfer_done && (state == S_RD_M || state == S_RD_S);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = res_valid && res_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign res_valid = (count != '0);
    assign res_data  = mem[rd_ptr][31:0];
    assign res_src   = mem[rd_ptr][32];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= {state == S_RD_S, avm_readdata};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 8'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (drop && ovf_q != 8'hFF)
                ovf_q <= ovf_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_ptp_sync_poller.sv
// Directed bench for ptp_sync_poller (POLL_PERIOD=10, TIMEOUT_CYCLES=64,
// FIFO_DEPTH=8). The bench plays the Avalon target: it watches for each
// request, holds waitrequest for a chosen number of cycles and supplies
// readdata. Outputs are sampled and inputs driven on the falling edge.
module tb_ptp_sync_poller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        role_master = 1'b0;
    logic [15:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_src;
    logic        busy, error;
    logic [7:0]  overflow_cnt;

    int vectors = 0;
    int miscompares = 0;
    int gap;
    int cnt;

    ptp_sync_poller #(
        .POLL_PERIOD(10), .TIMEOUT_CYCLES(64), .FIFO_DEPTH(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .role_master(role_master),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_src(res_src), .busy(busy), .error(error),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve one bus transfer: wait for the request, check it, stall nwait
    // cycles (optionally pulsing stop mid-stall), complete, and confirm the
    // request drops. gap = falling edges waited before the request appeared.
    task automatic xfer(input string tag, input bit is_rd, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int nwait,
                        input bit do_stop, output int g);
        g = 0;
        while (!(avm_read || avm_write) && g < 2000) begin
            @(negedge clock);
            g++;
        end
        chk({tag, " kind"}, 64'({avm_read, avm_write}), is_rd ? 64'd2 : 64'd1);
        chk({tag, " addr"}, 64'(avm_address), 64'(addr));
        if (!is_rd) chk({tag, " wdata"}, 64'(avm_writedata), 64'(wd));
        avm_readdata = rd;
        for (int i = 0; i < nwait; i++) begin
            avm_waitrequest = 1'b1;
            stop = do_stop && (i == 1);
            @(negedge clock);
        end
        stop = 1'b0;
        if (nwait > 0)
            chk({tag, " held"}, 64'({avm_read, avm_write, avm_address}),
                64'({is_rd, !is_rd, addr}));
        avm_waitrequest = 1'b0;
        @(negedge clock);
        chk({tag, " drop"}, 64'({avm_read, avm_write}), 64'd0);
    endtask

    task automatic pop(input string tag, input logic src, input logic [31:0] data);
        chk({tag, " valid"}, 64'(res_valid), 64'd1);
        chk({tag, " entry"}, 64'({src == res_src, res_data}), 64'({1'b1, data}));
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
    endtask

    task automatic pulse_start(input logic role);
        role_master = role;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " req"},   64'({avm_read, avm_write}), 64'd0);
        chk({tag, " addr"},  64'(avm_address), 64'd0);
        chk({tag, " wdata"}, 64'(avm_writedata), 64'd0);
        chk({tag, " busy"},  64'(busy), 64'd0);
        chk({tag, " error"}, 64'(error), 64'd0);
        chk({tag, " ovf"},   64'(overflow_cnt), 64'd0);
        chk({tag, " valid"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        // Master-role configuration sequence
        pulse_start(1'b1);
        chk("cfg busy", 64'(busy), 64'd1);
        xfer("cfg_rst",  0, 16'h0200, 32'd1, 32'd0, 0, 0, gap);
        xfer("cfg_role", 0, 16'h0000, 32'd1, 32'd0, 0, 0, gap);
        chk("cfg gap", 64'(gap), 64'd1);
        xfer("cfg_en",   0, 16'h0100, 32'd1, 32'd0, 0, 0, gap);

        // First poll: one wait cycle on each read
        xfer("rd_m", 1, 16'h0000, 32'd0, 32'h1234, 1, 0, gap);
        chk("poll gap first", 64'(gap), 64'd10);
        xfer("rd_s", 1, 16'h0100, 32'd0, 32'h5678, 1, 0, gap);
        chk("rd pair gap", 64'(gap), 64'd1);
        pop("fifo0", 1'b0, 32'h1234);
        pop("fifo1", 1'b1, 32'h5678);
        chk("fifo empty", 64'(res_valid), 64'd0);

        // Ten polls with res_ready low: 8 kept, 12 dropped.
        // The first gap is 8 because two cycles went to draining above.
        for (int i = 0; i < 10; i++) begin
            xfer("ovf rd_m", 1, 16'h0000, 32'd0, 32'h100 + i, 0, 0, gap);
            chk("ovf poll gap", 64'(gap), (i == 0) ? 64'd8 : 64'd10);
            xfer("ovf rd_s", 1, 16'h0100, 32'd0, 32'h200 + i, 0, 0, gap);
        end
        chk("ovf count", 64'(overflow_cnt), 64'd12);
        for (int k = 0; k < 4; k++) begin
            pop("drain m", 1'b0, 32'h100 + k);
            pop("drain s", 1'b1, 32'h200 + k);
        end
        chk("drain empty", 64'(res_valid), 64'd0);

        // Stop while RD_S is stalled: read completes, then disable write
        xfer("stop rd_m", 1, 16'h0000, 32'd0, 32'hAAAA0001, 0, 0, gap);
        xfer("stop rd_s", 1, 16'h0100, 32'd0, 32'hBBBB0002, 4, 1, gap);
        xfer("stop dis",  0, 16'h0100, 32'd0, 32'd0, 0, 0, gap);
        chk("stop idle busy", 64'(busy), 64'd0);
        pop("stop fifo m", 1'b0, 32'hAAAA0001);
        pop("stop fifo s", 1'b1, 32'hBBBB0002);
        chk("stop ovf kept", 64'(overflow_cnt), 64'd12);

        // Slave-role session, RD_M times out
        pulse_start(1'b0);
        xfer("cfg2_rst",  0, 16'h0200, 32'd1, 32'd0, 0, 0, gap);
        xfer("cfg2_role", 0, 16'h0000, 32'd0, 32'd0, 0, 0, gap);
        xfer("cfg2_en",   0, 16'h0100, 32'd1, 32'd0, 0, 0, gap);
        avm_waitrequest = 1'b1;
        cnt = 0;
        while (!avm_read && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        chk("tmo read seen", 64'(avm_read), 64'd1);
        cnt = 0;
        while (avm_read && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        chk("tmo read cycles", 64'(cnt), 64'd64);
        chk("tmo error", 64'(error), 64'd1);
        chk("tmo busy", 64'(busy), 64'd0);
        chk("tmo no push", 64'(res_valid), 64'd0);
        avm_waitrequest = 1'b0;
        @(negedge clock);
        chk("err holds", 64'({error, avm_read, avm_write}), 64'h4);

        // Start from ERR clears error; then stop during WAIT
        pulse_start(1'b1);
        chk("restart error", 64'(error), 64'd0);
        chk("restart busy", 64'(busy), 64'd1);
        xfer("cfg3_rst",  0, 16'h0200, 32'd1, 32'd0, 0, 0, gap);
        xfer("cfg3_role", 0, 16'h0000, 32'd1, 32'd0, 0, 0, gap);
        xfer("cfg3_en",   0, 16'h0100, 32'd1, 32'd0, 0, 0, gap);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        xfer("wait dis", 0, 16'h0100, 32'd0, 32'd0, 0, 0, gap);
        chk("wait dis gap", 64'(gap), 64'd0);
        chk("wait dis idle", 64'(busy), 64'd0);

        // Reset in the middle of a stalled CFG_ROLE write
        chk("pre-reset ovf", 64'(overflow_cnt), 64'd12);
        pulse_start(1'b1);
        xfer("cfg4_rst", 0, 16'h0200, 32'd1, 32'd0, 0, 0, gap);
        cnt = 0;
        while (!avm_write && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        avm_waitrequest = 1'b1;
        @(negedge clock);
        chk("cfg4_role held", 64'({avm_write, avm_address}), 64'h1_0000);
        reset = 1'b1;
        #1;
        chk_reset_values("midreset");
        avm_waitrequest = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post-reset idle", 64'({busy, avm_read, avm_write}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
